// File: rtl/machine_mode_types_1_12_pkg.sv
// rtl/machine_mode_types_1_12_pkg.sv - trap arbiter state type and cause priority tables
// Contents: trap_state_t, EXC_ORDER/EXC_NENT (exception causes, highest priority first),
//           int_order() (interrupt causes for a given NINT, highest priority first).
package machine_mode_types_1_12_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CLR = 2'd1,
    COMMIT   = 2'd2
  } trap_state_t;

  localparam int PRIV_M = 3;
  localparam int PRIV_S = 1;
  localparam int PRIV_U = 0;

  // Entry 0 is the highest priority; unused tail entries are never scanned.
  localparam int EXC_NENT = 14;
  localparam logic [31:0][4:0] EXC_ORDER = {
    {18{5'd0}},
    5'd5, 5'd7, 5'd13, 5'd15, 5'd4, 5'd6, 5'd11,
    5'd9, 5'd8, 5'd0, 5'd2, 5'd1, 5'd12, 5'd3
  };

  // Platform lines 16..nint-1 (highest index first), then the standard causes.
  function automatic logic [31:0][4:0] int_order(input int nint);
    logic [31:0][4:0] t;
    t = '0;
    for (int k = 0; k < nint - 16; k++) begin
      t[k] = 5'(nint - 1 - k);
    end
    t[nint - 16 + 0] = 5'd11;
    t[nint - 16 + 1] = 5'd3;
    t[nint - 16 + 2] = 5'd7;
    t[nint - 16 + 3] = 5'd9;
    t[nint - 16 + 4] = 5'd1;
    t[nint - 16 + 5] = 5'd5;
    return t;
  endfunction

endpackage

// File: rtl/priv_1_12_prio_enc.sv
// rtl/priv_1_12_prio_enc.sv - table-driven fixed-priority encoder
// Params: WIDTH (request width, <= 32), NENT (table entries), ORDER (cause per entry, entry 0 highest)
// Ports : req   [WIDTH-1:0] in  - request bits indexed by cause
//         valid             out - some listed cause is requesting
//         idx   [4:0]       out - highest-priority requesting cause
module priv_1_12_prio_enc #(
  parameter int               WIDTH = 16,
  parameter int               NENT  = 14,
  parameter logic [31:0][4:0] ORDER = '0
) (
  input  logic [WIDTH-1:0] req,
  output logic             valid,
  output logic [4:0]       idx
);

  // Padding to 32 lets every table entry index the request with a full 5-bit cause.
  logic [31:0] req_pad;
  assign req_pad = 32'(req);

  // Scan lowest priority first so the highest-priority hit is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = 5'd0;
    for (int k = NENT - 1; k >= 0; k--) begin
      if (req_pad[ORDER[k]]) begin
        valid = 1'b1;
        idx   = ORDER[k];
      end
    end
  end

endmodule

// File: rtl/priv_1_12_trap_arbiter.sv
// rtl/priv_1_12_trap_arbiter.sv - selects, holds and commits one trap or xRET at a time
// Build option: PRIV_1_12_SMODE_DELEG_EN enables S-mode delegation (mideleg/medeleg/mstatus_sie, sret).
// Ports : CLK, nRST (async, active-low)
//         int_pend[NINT-1:0], exc_req[15:0], curr_priv[1:0], mstatus_mie, mstatus_sie,
//         mideleg[NINT-1:0], medeleg[15:0], pipe_clear, mret, sret   - inputs
//         trap_req, trap_commit, trap_is_int, trap_cause[4:0], trap_to_s,
//         xret_commit[1:0] ({mret, sret})                           - outputs
module priv_1_12_trap_arbiter
  import machine_mode_types_1_12_pkg::*;
#(
  parameter int NINT = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NINT-1:0] int_pend,
  input  logic [15:0]     exc_req,
  input  logic [1:0]      curr_priv,
  input  logic            mstatus_mie,
  input  logic            mstatus_sie,
  input  logic [NINT-1:0] mideleg,
  input  logic [15:0]     medeleg,
  input  logic            pipe_clear,
  input  logic            mret,
  input  logic            sret,
  output logic            trap_req,
  output logic            trap_commit,
  output logic            trap_is_int,
  output logic [4:0]      trap_cause,
  output logic            trap_to_s,
  output logic [1:0]      xret_commit
);

  trap_state_t state_q, state_d;
  logic [4:0]  cause_q, cause_d;
  logic        is_int_q, is_int_d;
  logic        to_s_q, to_s_d;
  logic        trap_req_q, trap_req_d;
  logic        trap_commit_q, trap_commit_d;
  logic [1:0]  xret_q, xret_d;

  logic            in_m;
  logic            m_ok;
  logic [NINT-1:0] int_elig;
  logic            exc_v, int_v;
  logic [4:0]      exc_idx, int_idx;
  logic            exc_to_s, int_to_s;
  logic [1:0]      xret_req;

  assign in_m = (curr_priv == 2'(PRIV_M));
  // Below M an M-targeted interrupt is always enabled; in M it needs mstatus.MIE.
  assign m_ok = !in_m || mstatus_mie;

`ifdef PRIV_1_12_SMODE_DELEG_EN
  logic        s_ok;
  logic [31:0] mideleg_pad;
  logic [31:0] medeleg_pad;

  // Delegated interrupts are never taken in M.
  assign s_ok        = (curr_priv == 2'(PRIV_U)) ||
                       ((curr_priv == 2'(PRIV_S)) && mstatus_sie);
  assign mideleg_pad = 32'(mideleg);
  assign medeleg_pad = 32'(medeleg);
  assign int_elig    = int_pend & ((mideleg & {NINT{s_ok}}) | (~mideleg & {NINT{m_ok}}));
  assign exc_to_s    = medeleg_pad[exc_idx] && !in_m;
  assign int_to_s    = mideleg_pad[int_idx] && !in_m;
  assign xret_req    = {mret, sret};
`else
  logic unused_deleg;

  assign unused_deleg = ^{mideleg, medeleg, mstatus_sie, sret};
  assign int_elig     = int_pend & {NINT{m_ok}};
  assign exc_to_s     = 1'b0;
  assign int_to_s     = 1'b0;
  assign xret_req     = {mret, 1'b0};
`endif

  priv_1_12_prio_enc #(
    .WIDTH(16),
    .NENT (EXC_NENT),
    .ORDER(EXC_ORDER)
  ) u_exc_enc (
    .req  (exc_req),
    .valid(exc_v),
    .idx  (exc_idx)
  );

  priv_1_12_prio_enc #(
    .WIDTH(NINT),
    .NENT (NINT - 10),
    .ORDER(int_order(NINT))
  ) u_int_enc (
    .req  (int_elig),
    .valid(int_v),
    .idx  (int_idx)
  );

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    is_int_d      = is_int_q;
    to_s_d        = to_s_q;
    trap_req_d    = trap_req_q;
    trap_commit_d = 1'b0;
    xret_d        = 2'b00;
    case (state_q)
      IDLE: begin
        trap_req_d = 1'b0;
        if (exc_v) begin
          state_d    = WAIT_CLR;
          cause_d    = exc_idx;
          is_int_d   = 1'b0;
          to_s_d     = exc_to_s;
          trap_req_d = 1'b1;
        end else if (int_v) begin
          state_d    = WAIT_CLR;
          cause_d    = int_idx;
          is_int_d   = 1'b1;
          to_s_d     = int_to_s;
          trap_req_d = 1'b1;
        end else begin
          // An xRET racing a trap latch is dropped by the branches above.
          xret_d = xret_req;
        end
      end
      WAIT_CLR: begin
        // A synchronous exception preempts a pending interrupt, never another exception.
        if (exc_v && is_int_q) begin
          cause_d  = exc_idx;
          is_int_d = 1'b0;
          to_s_d   = exc_to_s;
        end
        if (pipe_clear) begin
          state_d       = COMMIT;
          trap_commit_d = 1'b1;
        end
      end
      COMMIT: begin
        state_d    = IDLE;
        trap_req_d = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        trap_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      cause_q       <= 5'd0;
      is_int_q      <= 1'b0;
      to_s_q        <= 1'b0;
      trap_req_q    <= 1'b0;
      trap_commit_q <= 1'b0;
      xret_q        <= 2'b00;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      is_int_q      <= is_int_d;
      to_s_q        <= to_s_d;
      trap_req_q    <= trap_req_d;
      trap_commit_q <= trap_commit_d;
      xret_q        <= xret_d;
    end
  end

  assign trap_req    = trap_req_q;
  assign trap_commit = trap_commit_q;
  assign trap_is_int = is_int_q;
  assign trap_cause  = cause_q;
  assign trap_to_s   = to_s_q;
  assign xret_commit = xret_q;

endmodule

// File: doc/priv_1_12_trap_arbiter.md
PRIV_1_12_TRAP_ARBITER -- requirements
Module: priv_1_12_trap_arbiter

Interface
REQ-001 SHALL have parameter NINT, default 16, legal range 16..32: number of interrupt lines (cause codes 0..NINT-1).
REQ-002 SHALL have clock CLK, input, 1 bit.
REQ-003 SHALL have reset nRST, input, 1 bit, asynchronous, active-low.
REQ-004 SHALL have int_pend, input, NINT bits: mip & mie, bit i = cause i.
REQ-005 SHALL have exc_req, input, 16 bits, one-hot per standard exception cause 0..15, valid for one cycle.
REQ-006 SHALL have curr_priv, input, 2 bits: 0 = U, 1 = S, 3 = M.
REQ-007 SHALL have mstatus_mie and mstatus_sie, inputs, 1 bit each.
REQ-008 SHALL have mideleg (NINT bits) and medeleg (16 bits), inputs.
REQ-009 SHALL have pipe_clear, input, 1 bit: pipeline drained.
REQ-010 SHALL have mret and sret, inputs, 1 bit each.
REQ-011 SHALL have trap_req, output, 1 bit: request flush to pipe control.
REQ-012 SHALL have trap_commit, output, 1 bit: one-cycle CSR update strobe.
REQ-013 SHALL have trap_is_int (1 bit), trap_cause (5 bits) and trap_to_s (1 bit), outputs, valid while trap_req or trap_commit is high.
REQ-014 SHALL have xret_commit, output, 2 bits: {mret, sret} strobe.

Function
REQ-015 FSM states: IDLE, WAIT_CLR, COMMIT.
REQ-016 Exception priority SHALL be fixed: 3, 12, 1, 2, 0, 8, 9, 11, 6, 4, 15, 13, 7, 5.
REQ-017 Interrupt priority SHALL be: lines 16..NINT-1, highest index first; then 11, 3, 7, 9, 1, 5.
REQ-018 Interrupt i eligible if int_pend[i] and its target permits it:
- M target (not delegated): curr_priv < M, or mstatus_mie = 1.
- S target (delegated): curr_priv = U, or (curr_priv = S and mstatus_sie = 1); never taken in M.
REQ-019 In IDLE, exc_req != 0 SHALL latch the highest-priority exception and move to WAIT_CLR; otherwise any eligible interrupt SHALL latch the highest-priority one and move to WAIT_CLR.
REQ-020 Exceptions SHALL beat interrupts in the same cycle.
REQ-021 trap_req SHALL be registered: high from cycle N+1 (event in cycle N) until COMMIT exits; it SHALL remain high if the interrupt source deasserts.
REQ-022 In WAIT_CLR, an exception SHALL overwrite a latched interrupt; it SHALL NOT overwrite a latched exception.
REQ-023 pipe_clear in WAIT_CLR SHALL move to COMMIT; trap_commit SHALL be high exactly one cycle, then return to IDLE.
REQ-024 pipe_clear in IDLE or COMMIT SHALL be ignored.
REQ-025 An mret/sret in IDLE with no trap latched SHALL pulse xret_commit for one cycle (registered).
REQ-026 An mret/sret coincident with a trap latch SHALL be dropped.
REQ-027 trap_to_s SHALL be 1 only if delegated and curr_priv != M at latch time.

Reset
REQ-028 nRST low SHALL force IDLE, with every output and latched cause, type and target cleared to 0, including mid-WAIT_CLR or mid-COMMIT.

Configuration
REQ-029 Macro PRIV_1_12_SMODE_DELEG_EN, when defined, SHALL make mideleg, medeleg and mstatus_sie active per REQ-018 and REQ-027.
REQ-030 When PRIV_1_12_SMODE_DELEG_EN is undefined:
- all traps SHALL target M;
- trap_to_s and xret_commit[0] SHALL be tied 0;
- the delegation inputs SHALL be unused, with ports retained.

Structure
REQ-031 machine_mode_types_1_12_pkg SHALL hold the trap_state_t enum and the exception/interrupt priority-order constants.
REQ-032 Arbitration SHALL use one sub-module, priv_1_12_prio_enc, parametrised by width and order table.

Verification
REQ-033 Bench SHALL cover the following scenarios:
- int_pend[7] = 1, priv = M, mie = 1 -> trap_req at N+1; pipe_clear at N+3 -> trap_commit at N+4, cause 7, is_int = 1.
- exc_req bit 2 and int_pend[11] in the same cycle -> cause 2, is_int = 0; interrupt taken after return to IDLE.
- Interrupt latched, exc_req bit 8 during WAIT_CLR -> cause 8; exc_req bit 3 afterwards -> cause stays 8.
- NINT = 20, int_pend bits 17 and 11 -> cause 17; priv = M, mie = 0 -> no trap_req.
- DELEG_EN, mideleg[5] = 1, priv = U -> trap_to_s = 1; priv = M -> ignored.
- nRST pulse during WAIT_CLR -> all outputs 0 next cycle, no trap_commit.
